// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: HUB75 row scanner with BCM bitplanes and global brightness.
// Pixel reads are prefetched one cycle ahead so each pixel's data is valid from its first low cycle.
module hub75_bcm_driver #(
   parameter int PANEL_ROWS  = 64,
   parameter int PANEL_COLS  = 64,
   parameter int CHAIN       = 1,
   parameter int COLOR_DEPTH = 4,
   parameter int ROW_W       = $clog2(PANEL_ROWS/2),
   parameter int ADDR_W      = $clog2(PANEL_ROWS/2*PANEL_COLS*CHAIN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [7:0]               prescale,
   input  logic [7:0]               brightness,
   output logic                     fb_rd_en,
   output logic [ADDR_W-1:0]        fb_rd_addr,
   input  logic [3*COLOR_DEPTH-1:0] fb_rd_upper,
   input  logic [3*COLOR_DEPTH-1:0] fb_rd_lower,
   output logic                     frame_done,
   output logic                     matrix_clk,
   output logic [ROW_W-1:0]         matrix_row,
   output logic [2:0]               matrix_rgb_upper,
   output logic [2:0]               matrix_rgb_lower,
   output logic                     matrix_oe_n,
   output logic                     matrix_stb
);
   localparam int W     = PANEL_COLS*CHAIN;
   localparam int ROWS  = PANEL_ROWS/2;
   localparam int COL_W = (W > 1) ? $clog2(W) : 1;
   localparam int PW    = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
   localparam int CW    = 8 + COLOR_DEPTH;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

   state_t            state, state_nx;
   logic [ROW_W-1:0]  row, row_nx, row_adv, rd_row;
   logic [PW-1:0]     plane, plane_nx, plane_adv;
   logic [COL_W-1:0]  col, col_nx, rd_col;
   logic              half, half_nx, start;
   logic [CW-1:0]     cnt, cnt_nx, disp_len;
   logic [7:0]        ps, br;
   logic [2:0]        rgbu_q, rgbl_q;
   logic              ph_end, disp_end, last_plane, last_row, wrap, load;

   function automatic logic [2:0] pick(input logic [3*COLOR_DEPTH-1:0] px, input logic [PW-1:0] p);
      logic [COLOR_DEPTH-1:0] r, g, b;
      r = px[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
      g = px[2*COLOR_DEPTH-1:COLOR_DEPTH];
      b = px[COLOR_DEPTH-1:0];
      return {r[p], g[p], b[p]};
   endfunction

   assign ph_end     = cnt == CW'(ps);
   assign disp_len   = CW'(256) << plane;
   assign disp_end   = (state == DISPLAY) && (cnt == disp_len - 1'b1);
   assign last_plane = plane == PW'(COLOR_DEPTH-1);
   assign last_row   = row == ROW_W'(ROWS-1);
   assign wrap       = disp_end && last_plane && last_row;
   assign load       = (state == SHIFT) && !half && (cnt == '0);
   assign plane_adv  = last_plane ? '0 : plane + 1'b1;
   assign row_adv    = !last_plane ? row : last_row ? '0 : row + 1'b1;

   always_comb begin
      state_nx = state;
      row_nx   = row;
      plane_nx = plane;
      col_nx   = col;
      half_nx  = half;
      cnt_nx   = cnt;
      rd_row   = row;
      rd_col   = col - 1'b1;
      fb_rd_en = 1'b0;
      start    = 1'b0;
      case (state)
         IDLE: if (enable && !rst) begin
            state_nx = SHIFT;
            row_nx   = '0;
            plane_nx = '0;
            col_nx   = COL_W'(W-1);
            half_nx  = 1'b0;
            cnt_nx   = '0;
            rd_row   = '0;
            rd_col   = COL_W'(W-1);
            fb_rd_en = 1'b1;
            start    = 1'b1;
         end
         SHIFT: begin
            cnt_nx = cnt + 1'b1;
            if (ph_end) begin
               cnt_nx  = '0;
               half_nx = !half;
               // last high cycle of a pixel fetches the next column
               if (half && col == '0) state_nx = LATCH;
               else if (half) begin
                  col_nx   = col - 1'b1;
                  fb_rd_en = 1'b1;
               end
            end
         end
         LATCH: begin
            cnt_nx = cnt + 1'b1;
            if (ph_end) begin
               cnt_nx   = '0;
               state_nx = DISPLAY;
            end
         end
         default: begin
            cnt_nx = cnt + 1'b1;
            if (disp_end) begin
               cnt_nx   = '0;
               row_nx   = row_adv;
               plane_nx = plane_adv;
               col_nx   = COL_W'(W-1);
               if (wrap && !enable) state_nx = IDLE;
               else begin
                  state_nx = SHIFT;
                  rd_row   = row_adv;
                  rd_col   = COL_W'(W-1);
                  fb_rd_en = 1'b1;
                  start    = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         row        <= '0;
         plane      <= '0;
         col        <= '0;
         half       <= 1'b0;
         cnt        <= '0;
         ps         <= '0;
         br         <= '0;
         rgbu_q     <= '0;
         rgbl_q     <= '0;
         matrix_row <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         row        <= row_nx;
         plane      <= plane_nx;
         col        <= col_nx;
         half       <= half_nx;
         cnt        <= cnt_nx;
         frame_done <= wrap;
         if (start) begin
            ps <= prescale;
            br <= brightness;
         end
         if (load) begin
            rgbu_q <= pick(fb_rd_upper, plane);
            rgbl_q <= pick(fb_rd_lower, plane);
         end
         if (state == SHIFT && state_nx == LATCH) matrix_row <= row;
      end
   end

   assign fb_rd_addr       = fb_rd_en ? ADDR_W'(rd_row) * ADDR_W'(W) + ADDR_W'(rd_col) : '0;
   assign matrix_clk       = (state == SHIFT) && half;
   assign matrix_stb       = state == LATCH;
   assign matrix_oe_n      = !((state == DISPLAY) && (cnt < (CW'(br) << plane)));
   assign matrix_rgb_upper = (state != SHIFT) ? 3'b0 : load ? pick(fb_rd_upper, plane) : rgbu_q;
   assign matrix_rgb_lower = (state != SHIFT) ? 3'b0 : load ? pick(fb_rd_lower, plane) : rgbl_q;
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: directed vectors for the HUB75 BCM driver on a 2x(4x4) chain, 2-bit colour.
module tb_hub75_bcm_driver;
   logic       clk = 1'b0, rst = 1'b0, enable = 1'b0;
   logic [7:0] prescale = 8'd0, brightness = 8'd10;
   logic       fb_rd_en, frame_done, matrix_clk, matrix_oe_n, matrix_stb;
   logic [3:0] fb_rd_addr;
   logic [5:0] fb_rd_upper = '0, fb_rd_lower = '0;
   logic [0:0] matrix_row;
   logic [2:0] matrix_rgb_upper, matrix_rgb_lower;

   hub75_bcm_driver #(.PANEL_ROWS(4), .PANEL_COLS(4), .CHAIN(2), .COLOR_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .enable(enable), .prescale(prescale), .brightness(brightness),
      .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_upper(fb_rd_upper),
      .fb_rd_lower(fb_rd_lower), .frame_done(frame_done), .matrix_clk(matrix_clk),
      .matrix_row(matrix_row), .matrix_rgb_upper(matrix_rgb_upper),
      .matrix_rgb_lower(matrix_rgb_lower), .matrix_oe_n(matrix_oe_n), .matrix_stb(matrix_stb)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] fu(input int a);
      return 6'(a*5 + 3);
   endfunction

   function automatic logic [5:0] fl(input int a);
      return 6'((a*11 + 7) ^ 42);
   endfunction

   function automatic logic [2:0] pick(input logic [5:0] px, input int p);
      return {px[4+p], px[2+p], px[p]};
   endfunction

   always @(posedge clk) if (fb_rd_en) begin
      fb_rd_upper <= fu(int'(fb_rd_addr));
      fb_rd_lower <= fl(int'(fb_rd_addr));
   end

   typedef struct {int ps; int br; int low0; int low1; int frame; int clk_per; int stb;} vec_t;
   vec_t vecs[5];

   int cyc, n_rise, n_stb, stb_run, row_bad, late_low, late_rd, pass_cnt, total;
   int low[4];
   int fd_t[$], rise_t[$], rise_at_stb[$], rows_at_stb[$], stb_len[$];
   logic [3:0] rd_q[$];
   logic [5:0] rgb_q[$];
   logic       prev_mclk, prev_stb;
   logic [0:0] prev_row;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (matrix_clk && !prev_mclk) begin
         n_rise++;
         rise_t.push_back(cyc);
         rgb_q.push_back({matrix_rgb_upper, matrix_rgb_lower});
      end
      if (matrix_stb && !prev_stb) begin
         n_stb++;
         rows_at_stb.push_back(int'(matrix_row));
         rise_at_stb.push_back(n_rise);
      end
      if (matrix_stb) stb_run++;
      else if (stb_run > 0) begin
         stb_len.push_back(stb_run);
         stb_run = 0;
      end
      if (!matrix_oe_n && n_stb >= 1 && n_stb <= 4) low[n_stb-1]++;
      if (matrix_row != prev_row && !matrix_oe_n) row_bad++;
      if (fb_rd_en) rd_q.push_back(fb_rd_addr);
      if (frame_done) fd_t.push_back(cyc);
      if (fd_t.size() > 0 && !matrix_oe_n) late_low++;
      if (fd_t.size() > 0 && fb_rd_en) late_rd++;
      prev_mclk = matrix_clk;
      prev_stb  = matrix_stb;
      prev_row  = matrix_row;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      cyc = 0; n_rise = 0; n_stb = 0; stb_run = 0; row_bad = 0; late_low = 0; late_rd = 0;
      for (int i = 0; i < 4; i++) low[i] = 0;
      fd_t.delete(); rise_t.delete(); rise_at_stb.delete(); rows_at_stb.delete();
      stb_len.delete(); rd_q.delete(); rgb_q.delete();
      prev_mclk = 1'b0; prev_stb = 1'b0; prev_row = matrix_row;
   endtask

   task automatic run_frames(input int ps, input int br);
      enable = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prescale = 8'(ps);
      brightness = 8'(br);
      clear_mon();
      enable = 1'b1;
      for (int i = 0; i < 5000 && fd_t.size() < 2; i++) tick();
      check("frame_done_count", fd_t.size(), 2);
   endtask

   function automatic int outs_or();
      return int'({fb_rd_en, fb_rd_addr, frame_done, matrix_clk, matrix_row,
                   matrix_rgb_upper, matrix_rgb_lower, matrix_stb});
   endfunction

   initial begin
      int rows_exp[5];
      int bad;
      vecs[0] = '{0, 10, 10, 20, 1604, 2, 1};
      vecs[1] = '{0, 0, 0, 0, 1604, 2, 1};
      vecs[2] = '{0, 255, 255, 510, 1604, 2, 1};
      vecs[3] = '{3, 10, 10, 20, 1808, 8, 4};
      vecs[4] = '{1, 100, 100, 200, 1672, 4, 2};
      rows_exp = '{0, 0, 1, 1, 0};
      pass_cnt = 0;
      total = 0;
      #2 rst = 1'b1;
      clear_mon();
      tick();
      check("reset_oe_n", int'(matrix_oe_n), 1);
      check("reset_outs", outs_or(), 0);
      rst = 1'b0;
      clear_mon();
      enable = 1'b1;
      repeat (810) tick();
      rst = 1'b1;
      tick();
      check("midrst_oe_n", int'(matrix_oe_n), 1);
      check("midrst_outs", outs_or(), 0);
      rst = 1'b0;
      clear_mon();
      for (int i = 0; i < 100 && n_stb < 1; i++) tick();
      check("restart_row", rows_at_stb.size() > 0 ? rows_at_stb[0] : -1, 0);
      check("restart_addr", rd_q.size() > 0 ? int'(rd_q[0]) : -1, 7);

      foreach (vecs[v]) begin
         run_frames(vecs[v].ps, vecs[v].br);
         check($sformatf("v%0d_low0", v), low[0], vecs[v].low0);
         check($sformatf("v%0d_low1", v), low[1], vecs[v].low1);
         check($sformatf("v%0d_first_fd", v), fd_t.size() > 0 ? fd_t[0] : -1, vecs[v].frame + 2);
         check($sformatf("v%0d_frame", v), fd_t.size() > 1 ? fd_t[1] - fd_t[0] : -1, vecs[v].frame);
         check($sformatf("v%0d_clk_per", v), rise_t.size() > 1 ? rise_t[1] - rise_t[0] : -1, vecs[v].clk_per);
         check($sformatf("v%0d_stb_len", v), stb_len.size() > 0 ? stb_len[0] : -1, vecs[v].stb);
      end

      run_frames(0, 10);
      for (int i = 0; i < 32; i++) begin
         int p, a;
         p = (i / 8) % 2;
         a = (i / 16) * 8 + 7 - (i % 8);
         check($sformatf("rgb_rise%0d", i), rgb_q.size() > i ? int'(rgb_q[i]) : -1,
               int'({pick(fu(a), p), pick(fl(a), p)}));
      end
      for (int k = 0; k < 4; k++)
         check($sformatf("rises_at_stb%0d", k), rise_at_stb.size() > k ? rise_at_stb[k] : -1, 8*(k+1));
      for (int k = 0; k < 5; k++)
         check($sformatf("row_at_stb%0d", k), rows_at_stb.size() > k ? rows_at_stb[k] : -1, rows_exp[k]);
      bad = 0;
      for (int i = 0; i < 16; i++)
         if (rd_q.size() <= i || int'(rd_q[i]) != 7 - (i % 8)) bad++;
      check("rd_addr_seq_errors", bad, 0);
      check("row_change_while_lit", row_bad, 0);

      enable = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prescale = 8'd0;
      brightness = 8'd10;
      clear_mon();
      enable = 1'b1;
      repeat (100) tick();
      enable = 1'b0;
      for (int i = 0; i < 3000 && fd_t.size() < 1; i++) tick();
      repeat (600) tick();
      check("drop_fd_count", fd_t.size(), 1);
      check("drop_fd_time", fd_t.size() > 0 ? fd_t[0] : -1, 1606);
      check("drop_late_reads", late_rd, 0);
      check("drop_late_oe_low", late_low, 0);
      check("drop_idle_oe_n", int'(matrix_oe_n), 1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/hub75_bcm_driver.md
Name: hub75_bcm_driver

Overview:
- Parametrised HUB75 panel scanner for chained multi-panel displays with any colour depth.
- Reads pixels from a dual-bank frame buffer (upper/lower half) and shifts out one bitplane per row pass.
- Drives per-plane on-time with binary-code modulation (BCM) and a global brightness.
- Sits between the frame-buffer RAM and the matrix connector, replacing the fixed-geometry 64x64 4-bit driver.

Parameters:
PANEL_ROWS, 64, physical rows per panel (even); scan rows = PANEL_ROWS/2
PANEL_COLS, 64, columns per panel
CHAIN, 1, panels daisy-chained horizontally; W = PANEL_COLS*CHAIN shifted pixels per row
COLOR_DEPTH, 4, bits per colour channel = number of bitplanes
ROW_W, $clog2(PANEL_ROWS/2), derived row-address width
ADDR_W, $clog2(PANEL_ROWS/2*W), derived frame-buffer address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  start/continue scanning
prescale  in  8  matrix_clk half-period = prescale+1 clk cycles
brightness  in  8  OE on-time unit, 0 = dark
fb_rd_en  out  1  frame-buffer read strobe
fb_rd_addr  out  ADDR_W  read address = row*W + col
fb_rd_upper  in  3*COLOR_DEPTH  {R,G,B} of row r, 1-cycle read latency
fb_rd_lower  in  3*COLOR_DEPTH  {R,G,B} of row r+PANEL_ROWS/2, same latency
frame_done  out  1  one-cycle pulse after last plane of last row
matrix_clk  out  1  HUB75 shift clock
matrix_row  out  ROW_W  HUB75 row address
matrix_rgb_upper  out  3  {R,G,B} bit for upper half
matrix_rgb_lower  out  3  {R,G,B} bit for lower half
matrix_oe_n  out  1  output enable, active low
matrix_stb  out  1  latch strobe

Behaviour:
- Reset values: matrix_oe_n=1; every other output 0. Internal counters row=0, plane=0, state IDLE. Reset mid-operation forces these values immediately, asynchronously.
- States:
  - IDLE: enable=1 -> SHIFT with row 0, plane 0.
  - SHIFT: W pixels.
  - LATCH: prescale+1 cycles.
  - DISPLAY: 256<<plane cycles.
  - DISPLAY end -> next plane. After plane COLOR_DEPTH-1 -> next row, plane 0. After last row/plane -> frame_done pulse, then SHIFT row 0 if enable=1, else IDLE.
- Transitions add zero cycles. One plane period = 2*W*(prescale+1) + (prescale+1) + (256<<plane).
- SHIFT:
  - Columns issued descending, W-1 to 0.
  - Per pixel, matrix_clk is low for prescale+1 cycles, then high for prescale+1 cycles.
  - matrix_rgb_* = bit `plane` of each channel (R = bits [3*CD-1:2*CD], G middle, B low).
  - Data must be valid from the first low cycle and stable until the falling edge that follows; the implementation prefetches reads.
  - matrix_oe_n=1 throughout SHIFT.
  - matrix_clk ends low; matrix_rgb_* return to 0 after the last pixel.
- LATCH: matrix_row <= current row on the first cycle. matrix_stb=1 for prescale+1 cycles. matrix_oe_n=1.
- DISPLAY: matrix_oe_n=0 for the first min(brightness<<plane, 256<<plane) cycles, then 1 for the remainder. Frame rate is independent of brightness.
- matrix_row changes only while matrix_oe_n=1 (anti-ghosting).
- prescale and brightness are sampled at the start of each plane; a change mid-plane takes effect on the next plane.
- enable=0 mid-frame: the current frame completes, frame_done pulses, then IDLE with matrix_oe_n=1.
- fb_rd_en is high only on cycles issuing a valid address; no reads outside SHIFT/prefetch.

Test Plan:
Params PANEL_ROWS=4, PANEL_COLS=4, CHAIN=2, COLOR_DEPTH=2, prescale=0, brightness=10, fb data = address-derived pattern.
1. Reset -> matrix_oe_n=1, all other outputs 0. Assert rst mid-SHIFT -> same values on the next sample, scan restarts at row 0 after release.
2. First plane -> exactly 8 matrix_clk rising edges. Addresses 7..0. Each edge's rgb equals bit 0 of fb data at that address; plane 1 carries bit 1.
3. BCM timing -> oe_n low 10 cycles in plane 0 (period 273), 20 cycles in plane 1 (period 529). Frame = 1604 cycles; frame_done pulses once per frame.
4. brightness=0 -> matrix_oe_n never 0. frame_done still every 1604 cycles. brightness=255 -> oe_n low 255/510 cycles.
5. Row sequencing -> matrix_row 0,0,1,1 across planes, then wraps to 0. Every matrix_row change coincides with oe_n=1. matrix_stb is one cycle per plane, only in LATCH.
6. Drop enable mid-row 0 -> frame completes, single frame_done, IDLE with oe_n=1, no further fb_rd_en. Prescale=3 -> 8-cycle matrix_clk period, 4-cycle stb.
